// File: rtl/noc_pkg.sv
// Shared flit types and helpers for the NoC network-interface blocks.
package noc_pkg;

  localparam int FLIT_W = 18;
  localparam int DATA_W = 16;

  localparam int TYPE_LSB      = 16;
  localparam int HEAD_LEN_LSB  = 12;
  localparam int HEAD_SRC_LSB  = 8;
  localparam int HEAD_DSTX_LSB = 4;
  localparam int HEAD_DSTY_LSB = 0;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    FT_IDLE = 2'b00,
    FT_HEAD = 2'b01,
    FT_BODY = 2'b10,
    FT_TAIL = 2'b11
  } flit_type_e;

  function automatic flit_t make_head(input logic [3:0] len,
                                      input logic [1:0] src_x,
                                      input logic [1:0] src_y,
                                      input logic [3:0] dst_x,
                                      input logic [3:0] dst_y);
    flit_t f;
    f = '0;
    f[TYPE_LSB +: 2]      = FT_HEAD;
    f[HEAD_LEN_LSB +: 4]  = len;
    f[HEAD_SRC_LSB +: 4]  = {src_x, src_y};
    f[HEAD_DSTX_LSB +: 4] = dst_x;
    f[HEAD_DSTY_LSB +: 4] = dst_y;
    return f;
  endfunction

endpackage

// File: rtl/noc_packetizer_if.sv
// Core-side command/data handshake plus the router L_IN flit link.
interface noc_packetizer_if;
  import noc_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_dst_x;
  logic [3:0]        cmd_dst_y;
  logic [3:0]        cmd_len;
  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data_in;
  flit_t             l_flit;
  logic              rtr_stall;
  logic [15:0]       pkt_sent;
  logic              err_len0;

  modport master (
    output cmd_valid, cmd_dst_x, cmd_dst_y, cmd_len, data_valid, data_in, rtr_stall,
    input  cmd_ready, data_ready, l_flit, pkt_sent, err_len0
  );

  modport slave (
    input  cmd_valid, cmd_dst_x, cmd_dst_y, cmd_len, data_valid, data_in, rtr_stall,
    output cmd_ready, data_ready, l_flit, pkt_sent, err_len0
  );

endinterface

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read; reused on the L_OUT side.
module noc_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A full FIFO still accepts a write when a word leaves in the same cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/noc_packetizer.sv
// NI injection stage: turns (dst,len) commands plus buffered data words into
// HEAD/BODY/TAIL wormhole flits on the router's local input port.
module noc_packetizer
  import noc_pkg::*;
#(
  parameter int NODE_X     = 0,
  parameter int NODE_Y     = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  noc_packetizer_if.slave   nif
);

  localparam int         CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] SRC_X = 2'(NODE_X);
  localparam logic [1:0] SRC_Y = 2'(NODE_Y);

  typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_DATA} state_e;

  state_e            r_state;
  flit_t             r_flit;
  logic              r_cmd_ready;
  logic              r_err_len0;
  logic [15:0]       r_pkt_sent;
  logic [3:0]        r_len;
  logic [3:0]        r_rem;
  logic [3:0]        r_dst_x;
  logic [3:0]        r_dst_y;

  logic [DATA_W-1:0] w_dout;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic              w_pop;
  flit_type_e        w_type;
  flit_type_e        w_dtype;
  logic              w_take;
  logic              w_can_load;

  assign w_type     = flit_type_e'(r_flit[TYPE_LSB +: 2]);
  assign w_take     = (w_type != FT_IDLE) && !nif.rtr_stall;
  // A stalled flit must stay on the link bit-for-bit until the router takes it.
  assign w_can_load = w_take || (w_type == FT_IDLE);
  assign w_dtype    = (r_rem == 4'd1) ? FT_TAIL : FT_BODY;
  assign w_pop      = (r_state == ST_DATA) && w_can_load && !w_empty;

  noc_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (nif.data_valid),
    .pop   (w_pop),
    .din   (nif.data_in),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign nif.cmd_ready  = r_cmd_ready;
  assign nif.data_ready = !w_full;
  assign nif.l_flit     = r_flit;
  assign nif.pkt_sent   = r_pkt_sent;
  assign nif.err_len0   = r_err_len0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_flit      <= '0;
      r_cmd_ready <= 1'b1;
      r_err_len0  <= 1'b0;
      r_pkt_sent  <= '0;
      r_len       <= '0;
      r_rem       <= '0;
      r_dst_x     <= '0;
      r_dst_y     <= '0;
    end else begin
      if (w_take && (w_type == FT_TAIL)) r_pkt_sent <= r_pkt_sent + 16'd1;
      case (r_state)
        ST_IDLE: begin
          if (w_can_load) r_flit <= '0;
          if (nif.cmd_valid && r_cmd_ready) begin
            if (nif.cmd_len != 4'd0) begin
              r_len       <= nif.cmd_len;
              r_rem       <= nif.cmd_len;
              r_dst_x     <= nif.cmd_dst_x;
              r_dst_y     <= nif.cmd_dst_y;
              r_cmd_ready <= 1'b0;
              r_state     <= ST_HEAD;
            end else begin
              r_err_len0  <= 1'b1;
            end
          end
        end
        ST_HEAD: begin
          if (w_can_load) begin
            r_flit  <= make_head(r_len, SRC_X, SRC_Y, r_dst_x, r_dst_y);
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_can_load) begin
            if (!w_empty) begin
              r_flit <= {w_dtype, w_dout};
              r_rem  <= r_rem - 4'd1;
              if (r_rem == 4'd1) begin
                r_state     <= ST_IDLE;
                r_cmd_ready <= 1'b1;
              end
            end else begin
              // Underflow: send a bubble and keep the worm open.
              r_flit <= '0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) w_full == (w_count == CNT_W'(FIFO_DEPTH)));

endmodule
